// File: rtl/irq_arbiter.sv
// Multi-channel IRQ collector/arbiter with a req/code/ack handshake to the core.
// Define IRQ_ARBITER_ROUND_ROBIN_EN for round-robin arbitration (default: fixed lowest-index priority).
module irq_arbiter #(
  parameter int unsigned         NUM_IRQ   = 8,
  parameter int unsigned         CODE_W    = 8,
  parameter logic [CODE_W-1:0]   CODE_BASE = 'h20,
  parameter logic [NUM_IRQ-1:0]  EDGE_MASK = '1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_IRQ-1:0]  irq_bi,
  input  logic [NUM_IRQ-1:0]  irq_en_bi,
  output logic                irq_req_o,
  output logic [CODE_W-1:0]   irq_code_bo,
  input  logic                irq_ack_i,
  output logic [NUM_IRQ-1:0]  irq_pending_bo
);

  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_req, w_req_nxt;
  logic [CODE_W-1:0]    r_code, w_code_nxt;
  logic [IDX_W-1:0]     r_winner, w_winner_nxt;
  logic [NUM_IRQ-1:0]   r_irq_buf;
  logic [NUM_IRQ-1:0]   r_pending, w_pending_nxt;
  logic [NUM_IRQ-1:0]   w_edge;
  logic [NUM_IRQ-1:0]   w_cand;
  logic                 w_found;
  logic [IDX_W-1:0]     w_sel;
  logic                 w_ack_clr;

  assign w_edge    = irq_bi & ~r_irq_buf;
  assign w_cand    = r_pending & irq_en_bi;
  assign w_ack_clr = (r_state == ST_REQ) && irq_ack_i;

`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_idx;

  // Search starts one past the last acked channel, wrapping modulo NUM_IRQ.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int unsigned j = 0; j < NUM_IRQ; j++) begin
      w_idx = IDX_W'((32'(r_ptr) + 32'd1 + j) % NUM_IRQ);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= IDX_W'(NUM_IRQ - 1);
    end else if (w_ack_clr) begin
      r_ptr <= r_winner;
    end
  end
`else
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (!w_found && w_cand[i]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(i);
      end
    end
  end
`endif

  // Edge channels: a new enabled edge beats a same-cycle ack of that channel.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_MASK[i]) begin
        if (w_edge[i] && irq_en_bi[i]) begin
          w_pending_nxt[i] = 1'b1;
        end else if (w_ack_clr && (r_winner == IDX_W'(i))) begin
          w_pending_nxt[i] = 1'b0;
        end
      end else begin
        w_pending_nxt[i] = irq_bi[i] & irq_en_bi[i];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_code_nxt   = r_code;
    w_winner_nxt = r_winner;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt  = ST_REQ;
          w_req_nxt    = 1'b1;
          w_code_nxt   = CODE_BASE + CODE_W'(w_sel);
          w_winner_nxt = w_sel;
        end
      end
      ST_REQ: begin
        if (irq_ack_i) begin
          w_state_nxt = ST_IDLE;
          w_req_nxt   = 1'b0;
          w_code_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_req_nxt   = 1'b0;
        w_code_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_code    <= '0;
      r_winner  <= '0;
      r_irq_buf <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= w_req_nxt;
      r_code    <= w_code_nxt;
      r_winner  <= w_winner_nxt;
      r_irq_buf <= irq_bi;
      r_pending <= w_pending_nxt;
    end
  end

  assign irq_req_o      = r_req;
  assign irq_code_bo    = r_code;
  assign irq_pending_bo = r_pending;

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: channel 0 level-sensitive, channels 1..7 edge-sensitive.
module tb_irq_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bi;
  logic [7:0] en;
  logic       ack;
  logic       req;
  logic [7:0] code;
  logic [7:0] pend;

  always #5 clk = ~clk;

  irq_arbiter #(
    .NUM_IRQ   (8),
    .CODE_W    (8),
    .CODE_BASE (8'h20),
    .EDGE_MASK (8'hFE)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .irq_bi         (bi),
    .irq_en_bi      (en),
    .irq_req_o      (req),
    .irq_code_bo    (code),
    .irq_ack_i      (ack),
    .irq_pending_bo (pend)
  );

`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
  logic [7:0] rr_bi = '0;
  logic [7:0] rr_en = '1;
  logic       rr_ack = 1'b0;
  logic       rr_req;
  logic [7:0] rr_code;
  logic [7:0] rr_pend;

  irq_arbiter #(
    .NUM_IRQ   (8),
    .CODE_W    (8),
    .CODE_BASE (8'h20),
    .EDGE_MASK (8'h00)
  ) rr_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .irq_bi         (rr_bi),
    .irq_en_bi      (rr_en),
    .irq_req_o      (rr_req),
    .irq_code_bo    (rr_code),
    .irq_ack_i      (rr_ack),
    .irq_pending_bo (rr_pend)
  );
`endif

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bi  = '0;
    en  = '1;
    ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Each request rising edge must carry the oldest queued code; code holds during REQ, 0 otherwise.
  logic       prev_req = 1'b0;
  logic [7:0] held_code = '0;
  always @(negedge clk) begin
    if (req && !prev_req) begin
      if (exp_q.size() == 0) check("sb_unexpected_req", {24'b0, code}, 32'h100);
      else                   check("sb_code", {24'b0, code}, {24'b0, exp_q.pop_front()});
      held_code = code;
    end else if (req) begin
      check("code_stable", {24'b0, code}, {24'b0, held_code});
    end else if (!rst) begin
      check("code_zero_idle", {24'b0, code}, 32'h0);
    end
    prev_req = req;
  end

  initial begin
    rst = 1'b1;
    bi  = '0;
    en  = '1;
    ack = 1'b0;
    #2;
    check("rst_req", req, 0);
    check("rst_code", code, 0);
    check("rst_pend", pend, 0);
    do_reset();

    // single edge pulse on channel 3
    bi[3] = 1'b1; exp_q.push_back(8'h23);
    tick();
    bi[3] = 1'b0;
    check("t1_pend", pend, 8'h08);
    check("t1_req_early", req, 0);
    tick();
    check("t1_req", req, 1);
    check("t1_code", code, 8'h23);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t1_ack_req", req, 0);
    check("t1_ack_code", code, 0);
    check("t1_ack_pend", pend, 0);
    tick(); tick();
    check("t1_quiet", req, 0);

    // simultaneous edges on 5 and 2
    do_reset();
    bi[5] = 1'b1; bi[2] = 1'b1;
    exp_q.push_back(8'h22); exp_q.push_back(8'h25);
    tick();
    check("t2_pend", pend, 8'h24);
    tick();
    check("t2_code1", code, 8'h22);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t2_gap", req, 0);
    check("t2_pend_left", pend, 8'h20);
    tick();
    check("t2_req2", req, 1);
    check("t2_code2", code, 8'h25);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t2_pend_done", pend, 0);
    bi = '0;
    tick();

    // edge on disabled channel 4 is dropped
    en[4] = 1'b0; bi[4] = 1'b1;
    tick();
    check("t3_pend", pend, 0);
    tick();
    check("t3_req", req, 0);
    en = '1;
    tick(); tick();
    check("t3_req_en", req, 0);
    check("t3_pend_en", pend, 0);
    bi = '0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    check("t3_idle_ack", req, 0);

    // level channel 0 re-requests while held
    do_reset();
    bi[0] = 1'b1; exp_q.push_back(8'h20);
    tick();
    check("t4_pend", pend, 8'h01);
    tick();
    check("t4_code1", code, 8'h20);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t4_gap", req, 0);
    check("t4_pend_held", pend, 8'h01);
    exp_q.push_back(8'h20);
    tick();
    check("t4_req2", req, 1);
    check("t4_code2", code, 8'h20);
    bi[0] = 1'b0;
    tick();
    check("t4_req_hold", req, 1);
    check("t4_pend_drop", pend, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(); tick(); tick();
    check("t4_no_more", req, 0);

    // new edge on channel 1 coincident with its own ack
    do_reset();
    bi[1] = 1'b1; exp_q.push_back(8'h21);
    tick();
    bi[1] = 1'b0;
    tick();
    check("t5_code1", code, 8'h21);
    bi[1] = 1'b1; ack = 1'b1; exp_q.push_back(8'h21);
    tick();
    ack = 1'b0; bi[1] = 1'b0;
    check("t5_gap", req, 0);
    check("t5_pend_kept", pend, 8'h02);
    tick();
    check("t5_req2", req, 1);
    check("t5_code2", code, 8'h21);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t5_req_done", req, 0);
    check("t5_pend_done", pend, 0);

    // asynchronous reset in the middle of a request
    do_reset();
    bi[3] = 1'b1; exp_q.push_back(8'h23);
    tick();
    bi[3] = 1'b0; bi[6] = 1'b1;
    tick();
    check("t6_req", req, 1);
    check("t6_pend", pend, 8'h48);
    #5;
    rst = 1'b1;
    #1;
    check("t6_rst_req", req, 0);
    check("t6_rst_code", code, 0);
    check("t6_rst_pend", pend, 0);
    bi = '0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("t6_after_req", req, 0);
    check("t6_after_pend", pend, 0);

`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
    // two permanently pending level channels alternate
    do_reset();
    rr_bi = 8'h03;
    tick(); tick();
    check("rr_code1", rr_code, 8'h20);
    rr_ack = 1'b1;
    tick();
    rr_ack = 1'b0;
    check("rr_gap1", rr_req, 0);
    tick();
    check("rr_code2", rr_code, 8'h21);
    rr_ack = 1'b1;
    tick();
    rr_ack = 1'b0;
    tick();
    check("rr_code3", rr_code, 8'h20);
    rr_bi = '0;
    rr_ack = 1'b1;
    tick();
    rr_ack = 1'b0;
    tick();
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Parametrised multi-channel successor to the single-button IRQ adapter.
- Collects NUM_IRQ interrupt lines, each configured as edge- or level-sensitive, and latches them into a pending register.
- Arbitrates among enabled pending sources and presents one request with a per-channel vector code to the core over the req/code/ack handshake.
- Sits between debounced/synchronous IRQ sources and the CPU core's interrupt input.

Parameters:
- NUM_IRQ, 8, number of interrupt channels (1..32).
- CODE_W, 8, width of the vector code output.
- CODE_BASE, 8'h20, code for channel 0. Channel i gets CODE_BASE+i. Requirement: CODE_BASE+NUM_IRQ-1 < 2^CODE_W.
- EDGE_MASK, all ones, per-channel mode: bit=1 rising-edge, bit=0 level-high.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- irq_bi  in  NUM_IRQ  interrupt lines; already synchronous to clk_i
- irq_en_bi  in  NUM_IRQ  per-channel enable
- irq_req_o  out  1  interrupt request to core
- irq_code_bo  out  CODE_W  vector code, valid while irq_req_o=1, else 0
- irq_ack_i  in  1  core acknowledge, 1-cycle pulse
- irq_pending_bo  out  NUM_IRQ  pending register, for status reads

Behaviour:
- Reset (async, rst_i=1): irq_req_o=0, irq_code_bo=0, irq_pending_bo=0, edge history=0, FSM=IDLE, round-robin pointer=NUM_IRQ-1.
- Edge detect: history register irq_buf <= irq_bi every cycle. Edge on channel i = !irq_buf[i] & irq_bi[i].
- Pending, edge channel:
  - Set on edge when irq_en_bi[i]=1; edges on disabled channels are dropped.
  - Cleared when the channel is acked.
  - An edge in the same cycle as its own ack: set wins, so the channel stays pending.
- Pending, level channel: pending[i] <= irq_bi[i] & irq_en_bi[i] every cycle; ack does not clear it.
- Arbitration: candidates = pending & irq_en_bi. Default is fixed priority, lowest index wins.
- FSM IDLE:
  - If any candidate exists: irq_req_o<=1, irq_code_bo<=CODE_BASE+winner, latch winner index, go to REQ.
  - Otherwise stay in IDLE.
- FSM REQ:
  - irq_req_o and irq_code_bo stay stable regardless of new pending bits or enable changes; no retraction.
  - On irq_ack_i=1: irq_req_o<=0, irq_code_bo<=0, clear pending[winner] if it is an edge channel, go to IDLE.
- irq_ack_i while IDLE is ignored.
- Latency:
  - Rising edge on irq_bi sampled at clock edge k gives pending=1 after edge k and irq_req_o=1 after edge k+1.
  - After an ack at edge m, the earliest next request is after edge m+1, so there is at least one idle cycle with req=0.
- Level channel still high after ack: re-requests after the one-cycle idle gap. The source must drop the line before acking.
- Reset asserted mid-REQ: everything clears immediately and the outstanding request is lost.

Optional Feature:
- IRQ_ARBITER_ROUND_ROBIN_EN defined:
  - Arbitration searches candidates starting at pointer+1, modulo NUM_IRQ.
  - Pointer <= winner on each ack.
  - Reset pointer = NUM_IRQ-1, so channel 0 is searched first.
- IRQ_ARBITER_ROUND_ROBIN_EN undefined: fixed lowest-index priority; no pointer register is synthesised.

Test Plan:
- Default params, irq_en_bi=8'hFF. Pulse irq_bi[3] for 1 cycle → irq_req_o=1 two cycles later with irq_code_bo=8'h23. Ack → req=0, code=0, pending=0.
- irq_bi[5] and irq_bi[2] rise in the same cycle → first code 8'h22. After ack, one idle cycle, then code 8'h25.
- irq_en_bi[4]=0, edge on channel 4 → no pending, no req. Set en=1 afterwards → still no req, because the edge was dropped.
- EDGE_MASK=8'hFE, hold irq_bi[0]=1 → code 8'h20 requested. Ack → re-request after one idle cycle. Drop irq_bi[0] before the second ack → no further request.
- New edge on channel 1 during REQ for channel 1; ack in that same cycle → pending[1] stays 1 and a new request with 8'h21 follows.
- Assert rst_i asynchronously mid-REQ → irq_req_o, irq_code_bo and irq_pending_bo go to 0 before the next clock edge.
- With IRQ_ARBITER_ROUND_ROBIN_EN: channels 0 and 1 held permanently pending (level) → codes alternate 8'h20, 8'h21, 8'h20 over successive acks.
